// File: rtl/wbuf_alloc_ctrl.sv
// rtl/wbuf_alloc_ctrl.sv - write-buffer slot allocator with round-robin requester arbitration

package mpc_pkg;
    typedef struct packed {
        logic [15:0] wbufSize;
    } mpc_u_t;

    typedef struct packed {
        mpc_u_t u;
    } mpc_cfg_t;
endpackage

module wbuf_alloc_ctrl #(
    parameter mpc_pkg::mpc_cfg_t Cfg         = '0,
    parameter type               wbufWidth_t = logic,
    parameter int                NumReq      = 4,
    // An unset configuration (wbufSize below 2) falls back to a two-entry buffer.
    localparam int N    = (int'(Cfg.u.wbufSize) < 2) ? 2 : int'(Cfg.u.wbufSize),
    localparam int CntW = $clog2(N + 1),
    localparam int PtrW = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NumReq-1:0] alloc_req_valid,
    output logic [NumReq-1:0] alloc_gnt,
    output wbufWidth_t        alloc_gnt_id,
    input  logic              free_valid,
    input  wbufWidth_t        free_id,
    output logic [CntW-1:0]   free_cnt,
    output logic              wbuf_full,
    output logic              err_double_free
);

    logic [N-1:0]      free_map_q, free_map_d;
    logic [PtrW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CntW-1:0]   free_cnt_q, free_cnt_d;
    logic              err_q, err_d;

    logic              ent_found;
    wbufWidth_t        ent_id;
    logic [N-1:0]      ent_onehot;

    logic              win_found;
    logic [PtrW-1:0]   win_idx;
    logic [NumReq-1:0] win_onehot;

    logic              grant;
    logic [N-1:0]      free_onehot;
    logic              free_hit;
    logic              legal_free;
    logic              bad_free;

    // Pick the lowest-index free entry from the registered map.
    always_comb begin
        ent_found  = 1'b0;
        ent_id     = '0;
        ent_onehot = '0;
        for (int i = 0; i < N; i++) begin
            if (!ent_found && free_map_q[i]) begin
                ent_found     = 1'b1;
                ent_id        = wbufWidth_t'(i);
                ent_onehot[i] = 1'b1;
            end
        end
    end

    // Round-robin winner: first asserted requester at or above rr_ptr, else wrap to the bottom.
    always_comb begin
        win_found  = 1'b0;
        win_idx    = '0;
        win_onehot = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (!win_found && alloc_req_valid[i] && (i >= int'(rr_ptr_q))) begin
                win_found     = 1'b1;
                win_idx       = PtrW'(i);
                win_onehot[i] = 1'b1;
            end
        end
        for (int i = 0; i < NumReq; i++) begin
            if (!win_found && alloc_req_valid[i]) begin
                win_found     = 1'b1;
                win_idx       = PtrW'(i);
                win_onehot[i] = 1'b1;
            end
        end
    end

    // Decode the release: only an in-range entry that is currently allocated is legal.
    always_comb begin
        free_onehot = '0;
        free_hit    = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (free_id == wbufWidth_t'(i)) begin
                free_onehot[i] = 1'b1;
                free_hit       = !free_map_q[i];
            end
        end
    end

    assign grant      = !rst && win_found && ent_found && (free_cnt_q != '0);
    assign legal_free = free_valid && free_hit;
    assign bad_free   = free_valid && !free_hit;

    assign alloc_gnt       = grant ? win_onehot : '0;
    assign alloc_gnt_id    = grant ? ent_id : '0;
    assign free_cnt        = free_cnt_q;
    assign wbuf_full       = (free_cnt_q == '0);
    assign err_double_free = err_q;

    // Next-state: grant clears, a legal release sets; the two never touch the same entry.
    always_comb begin
        free_map_d = free_map_q;
        if (grant) begin
            free_map_d = free_map_d & ~ent_onehot;
        end
        if (legal_free) begin
            free_map_d = free_map_d | free_onehot;
        end

        rr_ptr_d = rr_ptr_q;
        if (grant) begin
            rr_ptr_d = (win_idx == PtrW'(NumReq - 1)) ? '0 : win_idx + PtrW'(1);
        end

        free_cnt_d = free_cnt_q;
        if (grant && !legal_free) begin
            free_cnt_d = free_cnt_q - CntW'(1);
        end else if (!grant && legal_free) begin
            free_cnt_d = free_cnt_q + CntW'(1);
        end

        err_d = err_q | bad_free;
    end

    // State registers; reset frees every entry and forgets all outstanding IDs.
    always_ff @(posedge clk) begin
        if (rst) begin
            free_map_q <= '1;
            free_cnt_q <= CntW'(N);
            rr_ptr_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            free_map_q <= free_map_d;
            free_cnt_q <= free_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_wbuf_alloc_ctrl.sv
// tb/tb_wbuf_alloc_ctrl.sv - self-checking bench for wbuf_alloc_ctrl (N=4, NumReq=2)

module tb_wbuf_alloc_ctrl;

    localparam int N  = 4;
    localparam int NR = 2;
    localparam mpc_pkg::mpc_cfg_t CFG = '{u: '{wbufSize: 16'd4}};

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] alloc_req_valid;
    logic [1:0] alloc_gnt;
    logic [1:0] alloc_gnt_id;
    logic       free_valid;
    logic [1:0] free_id;
    logic [2:0] free_cnt;
    logic       wbuf_full;
    logic       err_double_free;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    wbuf_alloc_ctrl #(
        .Cfg         (CFG),
        .wbufWidth_t (logic [1:0]),
        .NumReq      (NR)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .alloc_req_valid (alloc_req_valid),
        .alloc_gnt       (alloc_gnt),
        .alloc_gnt_id    (alloc_gnt_id),
        .free_valid      (free_valid),
        .free_id         (free_id),
        .free_cnt        (free_cnt),
        .wbuf_full       (wbuf_full),
        .err_double_free (err_double_free)
    );

    task automatic drive(input logic r, input logic [1:0] req, input logic fv, input logic [1:0] fid);
        rst             = r;
        alloc_req_valid = req;
        free_valid      = fv;
        free_id         = fid;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(1'b1, 2'b00, 1'b0, 2'd0);
        tick();
    endtask

    task automatic test_reset();
        drive(1'b1, 2'b11, 1'b1, 2'd0);
        vectors++;
        if (alloc_gnt !== 2'b00 || alloc_gnt_id !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_gnt: gnt=%b id=%0d, expected gnt=00 id=0", alloc_gnt, alloc_gnt_id);
        end
        tick();
        drive(1'b0, 2'b00, 1'b0, 2'd0);
        vectors++;
        if (free_cnt !== 3'd4 || wbuf_full !== 1'b0 || err_double_free !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: cnt=%0d full=%b err=%b, expected cnt=4 full=0 err=0",
                     free_cnt, wbuf_full, err_double_free);
        end
        vectors++;
        if (alloc_gnt !== 2'b00 || alloc_gnt_id !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_idle_gnt: gnt=%b id=%0d, expected gnt=00 id=0", alloc_gnt, alloc_gnt_id);
        end
    endtask

    task automatic test_fill_single();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 2'b01, 1'b0, 2'd0);
            vectors++;
            if (alloc_gnt !== 2'b01 || alloc_gnt_id !== 2'(i)) begin
                miscompares++;
                $display("FAIL fill_gnt[%0d]: gnt=%b id=%0d, expected gnt=01 id=%0d", i, alloc_gnt, alloc_gnt_id, i);
            end
            vectors++;
            if (free_cnt !== 3'(4 - i) || wbuf_full !== 1'b0) begin
                miscompares++;
                $display("FAIL fill_cnt[%0d]: cnt=%0d full=%b, expected cnt=%0d full=0", i, free_cnt, wbuf_full, 4 - i);
            end
            tick();
        end
        drive(1'b0, 2'b01, 1'b0, 2'd0);
        vectors++;
        if (free_cnt !== 3'd0 || wbuf_full !== 1'b1 || alloc_gnt !== 2'b00) begin
            miscompares++;
            $display("FAIL fill_full: cnt=%0d full=%b gnt=%b, expected cnt=0 full=1 gnt=00",
                     free_cnt, wbuf_full, alloc_gnt);
        end
    endtask

    task automatic test_alternate();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 2'b11, 1'b0, 2'd0);
            vectors++;
            if (alloc_gnt !== ((i % 2 == 0) ? 2'b01 : 2'b10) || alloc_gnt_id !== 2'(i)) begin
                miscompares++;
                $display("FAIL alt_gnt[%0d]: gnt=%b id=%0d, expected gnt=%b id=%0d", i, alloc_gnt, alloc_gnt_id,
                         (i % 2 == 0) ? 2'b01 : 2'b10, i);
            end
            tick();
        end
    endtask

    task automatic test_full_free();
        drive(1'b0, 2'b10, 1'b1, 2'd2);
        vectors++;
        if (alloc_gnt !== 2'b00 || free_cnt !== 3'd0) begin
            miscompares++;
            $display("FAIL fullfree_cycle: gnt=%b cnt=%0d, expected gnt=00 cnt=0", alloc_gnt, free_cnt);
        end
        tick();
        drive(1'b0, 2'b10, 1'b0, 2'd0);
        vectors++;
        if (alloc_gnt !== 2'b10 || alloc_gnt_id !== 2'd2 || free_cnt !== 3'd1) begin
            miscompares++;
            $display("FAIL fullfree_reuse: gnt=%b id=%0d cnt=%0d, expected gnt=10 id=2 cnt=1",
                     alloc_gnt, alloc_gnt_id, free_cnt);
        end
        tick();
        drive(1'b0, 2'b00, 1'b0, 2'd0);
        vectors++;
        if (free_cnt !== 3'd0 || wbuf_full !== 1'b1) begin
            miscompares++;
            $display("FAIL fullfree_after: cnt=%0d full=%b, expected cnt=0 full=1", free_cnt, wbuf_full);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 2'b01, 1'b0, 2'd0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'b00, 1'b1, 2'(i));
            tick();
        end
        drive(1'b0, 2'b01, 1'b1, 2'd3);
        vectors++;
        if (alloc_gnt !== 2'b01 || alloc_gnt_id !== 2'd0 || free_cnt !== 3'd3) begin
            miscompares++;
            $display("FAIL simul_gnt: gnt=%b id=%0d cnt=%0d, expected gnt=01 id=0 cnt=3",
                     alloc_gnt, alloc_gnt_id, free_cnt);
        end
        tick();
        for (int i = 1; i <= 3; i++) begin
            drive(1'b0, 2'b01, 1'b0, 2'd0);
            vectors++;
            if (alloc_gnt !== 2'b01 || alloc_gnt_id !== 2'(i) || free_cnt !== 3'(4 - i)) begin
                miscompares++;
                $display("FAIL simul_next[%0d]: gnt=%b id=%0d cnt=%0d, expected gnt=01 id=%0d cnt=%0d",
                         i, alloc_gnt, alloc_gnt_id, free_cnt, i, 4 - i);
            end
            tick();
        end
    endtask

    task automatic test_double_free();
        do_reset();
        drive(1'b0, 2'b00, 1'b1, 2'd1);
        vectors++;
        if (err_double_free !== 1'b0) begin
            miscompares++;
            $display("FAIL dfree_pre: err=%b, expected err=0", err_double_free);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'b00, 1'b0, 2'd0);
            vectors++;
            if (err_double_free !== 1'b1 || free_cnt !== 3'd4) begin
                miscompares++;
                $display("FAIL dfree_sticky[%0d]: err=%b cnt=%0d, expected err=1 cnt=4", i, err_double_free, free_cnt);
            end
            tick();
        end
        do_reset();
        drive(1'b0, 2'b00, 1'b0, 2'd0);
        vectors++;
        if (err_double_free !== 1'b0) begin
            miscompares++;
            $display("FAIL dfree_clear: err=%b, expected err=0", err_double_free);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'b01, 1'b0, 2'd0);
            tick();
        end
        drive(1'b1, 2'b11, 1'b0, 2'd0);
        vectors++;
        if (alloc_gnt !== 2'b00) begin
            miscompares++;
            $display("FAIL midrst_gnt: gnt=%b, expected gnt=00", alloc_gnt);
        end
        tick();
        drive(1'b0, 2'b11, 1'b0, 2'd0);
        vectors++;
        if (free_cnt !== 3'd4 || alloc_gnt !== 2'b01 || alloc_gnt_id !== 2'd0) begin
            miscompares++;
            $display("FAIL midrst_after: cnt=%0d gnt=%b id=%0d, expected cnt=4 gnt=01 id=0",
                     free_cnt, alloc_gnt, alloc_gnt_id);
        end
        tick();
    endtask

    task automatic test_random();
        bit         is_free[N];
        int         cnt;
        int         rr;
        bit         err;
        int         outst[$];
        logic       r;
        logic [1:0] req;
        logic       fv;
        logic [1:0] fid;
        logic [1:0] exp_gnt;
        logic [1:0] exp_id;
        int         win;
        bit         legal;

        do_reset();
        for (int e = 0; e < N; e++) is_free[e] = 1'b1;
        cnt = N;
        rr  = 0;
        err = 1'b0;
        outst.delete();

        for (int cyc = 0; cyc < 400; cyc++) begin
            r   = ($urandom_range(0, 59) == 0);
            req = 2'($urandom_range(0, 3));
            fv  = ($urandom_range(0, 2) == 0);
            if (outst.size() > 0 && $urandom_range(0, 4) != 0)
                fid = 2'(outst[$urandom_range(0, outst.size() - 1)]);
            else
                fid = 2'($urandom_range(0, 3));
            drive(r, req, fv, fid);

            win     = -1;
            exp_gnt = 2'b00;
            exp_id  = 2'd0;
            if (!r && cnt > 0) begin
                for (int k = 0; k < NR; k++) begin
                    if (win < 0 && req[(rr + k) % NR]) win = (rr + k) % NR;
                end
            end
            if (win >= 0) begin
                exp_gnt = 2'(1 << win);
                for (int e = N - 1; e >= 0; e--) begin
                    if (is_free[e]) exp_id = 2'(e);
                end
            end

            vectors++;
            if (alloc_gnt !== exp_gnt || alloc_gnt_id !== exp_id) begin
                miscompares++;
                $display("FAIL rand_gnt[%0d]: gnt=%b id=%0d, expected gnt=%b id=%0d",
                         cyc, alloc_gnt, alloc_gnt_id, exp_gnt, exp_id);
            end
            vectors++;
            if (free_cnt !== 3'(cnt) || wbuf_full !== (cnt == 0) || err_double_free !== err) begin
                miscompares++;
                $display("FAIL rand_state[%0d]: cnt=%0d full=%b err=%b, expected cnt=%0d full=%b err=%b",
                         cyc, free_cnt, wbuf_full, err_double_free, cnt, (cnt == 0), err);
            end
            tick();

            if (r) begin
                for (int e = 0; e < N; e++) is_free[e] = 1'b1;
                cnt = N;
                rr  = 0;
                err = 1'b0;
                outst.delete();
            end else begin
                legal = fv && !is_free[fid];
                if (win >= 0) begin
                    is_free[exp_id] = 1'b0;
                    cnt--;
                    outst.push_back(int'(exp_id));
                    rr = (win + 1) % NR;
                end
                if (legal) begin
                    is_free[fid] = 1'b1;
                    cnt++;
                    for (int j = 0; j < outst.size(); j++) begin
                        if (outst[j] == int'(fid)) begin
                            outst.delete(j);
                            break;
                        end
                    end
                end else if (fv) begin
                    err = 1'b1;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_single();
        test_alternate();
        test_full_free();
        test_simultaneous();
        test_double_free();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wbuf_alloc_ctrl.md
# wbuf_alloc_ctrl

Slot allocator and requester arbiter for the write buffer. Tracks which write-buffer entries are free, grants at most one entry ID per cycle to one of several requesters under round-robin arbitration, and reclaims entries when the write buffer reports a read-out via its free response (`xbar_rsp_free_valid` / `xbar_rsp_free_id`). The granted ID is what the requester later places in `xbar_req.wbuf_id` when it writes data into the buffer.

## Interface
Parameters:
- `Cfg`: default `'0`. `mpc_cfg_t`. Entry count `N = Cfg.u.wbufSize`, with N ≥ 2.
- `wbufWidth_t`: default `logic`. Entry ID type, wide enough for N-1.
- `NumReq`: default 4. Number of allocation requesters, with NumReq ≥ 1.

Ports:
- `clk`: input, 1 bit. The single clock; all state updates on its rising edge.
- `rst`: input, 1 bit. Reset, synchronous, active-high.
- `alloc_req_valid`: input, NumReq bits. Per-requester allocation request, level.
- `alloc_gnt`: output, NumReq bits. One-hot grant for this cycle; all zero when nothing is granted.
- `alloc_gnt_id`: output, wbufWidth_t. Entry ID handed to the granted requester; valid only while `|alloc_gnt`.
- `free_valid`: input, 1 bit. Entry release, driven from the write buffer's `xbar_rsp_free_valid`.
- `free_id`: input, wbufWidth_t. Entry being released, driven from `xbar_rsp_free_id`.
- `free_cnt`: output, $clog2(N+1) bits. Registered count of free entries.
- `wbuf_full`: output, 1 bit. High when `free_cnt == 0`.
- `err_double_free`: output, 1 bit. Sticky error flag; cleared only by `rst`.

## Operation
- State consists of:
  - `free_map[N-1:0]`: 1 = entry free.
  - `rr_ptr`: requester index, $clog2(NumReq) bits, or 1 bit when NumReq = 1.
  - `free_cnt`.
  - `err_double_free`.
- Reset (`rst` = 1 at an edge) sets:
  - `free_map` = all ones.
  - `free_cnt` = N.
  - `rr_ptr` = 0.
  - `err_double_free` = 0.
- While `rst` is high, `alloc_gnt` is forced to 0. An allocation or free presented in a reset cycle is discarded.
- Entry selection: the lowest-index set bit of the registered `free_map`.
- Arbitration: round-robin among the asserted `alloc_req_valid` bits.
  - Search starts at `rr_ptr` and wraps modulo NumReq.
  - The first asserted requester found wins.
- A grant is issued iff `free_cnt != 0` and `|alloc_req_valid`.
- On a grant at requester g, at the next edge:
  - Clear the granted entry's bit in `free_map`.
  - Set `rr_ptr` = (g+1) mod NumReq.
- With no grant, `rr_ptr` holds its value.
- Free handling, evaluated at the edge against the registered `free_map`:
  - If `free_id` < N and `free_map[free_id]` == 0: set the bit.
  - If `free_id` ≥ N, or the entry is already free: ignore the release (no map or count change) and set `err_double_free`.
- Simultaneous grant and free in the same cycle:
  - Both take effect at the edge.
  - `free_cnt` is unchanged.
  - The freed entry is not grantable until the following cycle.
  - The granted entry is always one that was free, so it never equals a valid `free_id`.
- Count rule: `free_cnt_next = free_cnt - grant + legal_free`. It never exceeds N or goes below 0.
- Requesters must treat the grant as taken. There is no cancel path; an unused ID must be returned through the free path.

## Timing
- Grant latency is 0 cycles.
  - `alloc_gnt` and `alloc_gnt_id` are combinational from `alloc_req_valid`, the registered `free_map` and `rr_ptr`.
  - There is no combinational path from `free_valid` or `free_id` to any output.
- Free-to-reuse latency is 1 cycle: an entry freed at edge k can be granted in the cycle after edge k.
- `free_cnt`, `wbuf_full` and `err_double_free` are registered and reflect all grants and frees up to the last edge.
- Sustained throughput is one allocation per cycle while entries remain.
- Full state: with `free_cnt` = 0, no grant. Arbitration order (`rr_ptr`) is preserved until an entry returns.
- Reset values:
  - `alloc_gnt` = 0.
  - `alloc_gnt_id` = 0. Don't-care while no grant; drive 0.
  - `free_cnt` = N.
  - `wbuf_full` = 0.
  - `err_double_free` = 0.
- Reset asserted mid-operation: all outstanding IDs are forgotten and every entry becomes free at that edge.

## Test plan
All scenarios use N = 4 and NumReq = 2.
- Reset, then `alloc_req_valid` = 2'b01 for 4 cycles:
  - IDs 0, 1, 2, 3 are granted to requester 0.
  - `free_cnt` steps 4→3→2→1→0.
  - `wbuf_full` = 1 after the 4th edge.
  - A 5th cycle gives `alloc_gnt` = 0.
- Both requesters valid for 4 cycles from reset:
  - Grants alternate req0, req1, req0, req1.
  - IDs are 0, 1, 2, 3 in order.
- Buffer full; free `free_id` = 2 at edge k with `alloc_req_valid` = 2'b10 held:
  - No grant in the cycle of the free.
  - The next cycle grants req1 with ID 2.
  - `free_cnt` goes 0→1→0.
- Grant ID 0 in the same cycle as free of ID 3, with 3 previously allocated:
  - `free_cnt` unchanged.
  - The next grant returns ID 1 (lowest free index is 1, since 3 is not yet lower).
  - After allocating 1 and 2, the next grant returns ID 3.
- Free ID 1 while entry 1 is already free:
  - `free_cnt` unchanged.
  - `err_double_free` = 1 from the next cycle onward.
  - The flag stays set until `rst` and then clears.
- Assert `rst` for one cycle with 3 entries allocated and requests pending:
  - `alloc_gnt` = 0 during the reset cycle.
  - The following cycle shows `free_cnt` = 4, and the next grant is ID 0 to req0.
